// File: rtl/dht11_uart_report.sv
`default_nettype none
// ============================================================================
// Module : dht11_uart_report
// Desc   : Captures a DHT11 reading on a done edge, prints "H=hhh.f T=ttt.f\r\n"
//          over 8N1 UART. Define DHT_REPORT_ERR_EN to also send "ERR\r\n" on erro.
// Rev    : 1.0
// ============================================================================
module dht11_uart_report #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_valid,
    input  logic        done,
    input  logic        erro,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  report_cnt
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam int MSG_LEN  = 17;
    localparam logic [4:0] LAST_DATA = 5'd16;
    localparam logic [4:0] LAST_ERR  = 5'd4;

    typedef enum logic [2:0] {IDLE, CONV, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [4:0]       chr_q, chr_d;
    logic [4:0]       last_q, last_d;
    logic [2:0]       conv_q, conv_d;
    logic [19:0]      dd_h_q, dd_h_d;
    logic [19:0]      dd_t_q, dd_t_d;
    logic [7:0]       frac_h_q, frac_h_d;
    logic [7:0]       frac_t_q, frac_t_d;
    logic [7:0]       msg_q [MSG_LEN];
    logic [7:0]       msg_d [MSG_LEN];
    logic             done_meta_q, done_meta_d;
    logic             done_sync_q, done_sync_d;
    logic             done_prev_q, done_prev_d;
    logic             done_evt;
    logic             err_evt;
    logic             baud_end;

`ifdef DHT_REPORT_ERR_EN
    logic             erro_meta_q, erro_meta_d;
    logic             erro_sync_q, erro_sync_d;
    logic             erro_prev_q, erro_prev_d;

    assign err_evt = erro_sync_q & ~erro_prev_q;
`else
    logic             unused_erro;

    assign unused_erro = erro;
    assign err_evt     = 1'b0;
`endif

    assign done_evt = done_sync_q & ~done_prev_q;
    assign baud_end = (baud_q == BAUD_LAST);

    // Double-dabble step: {hundreds, tens, ones, binary}, 8 steps per byte.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[19:16] > 4'd4) t[19:16] = t[19:16] + 4'd3;
        if (t[15:12] > 4'd4) t[15:12] = t[15:12] + 4'd3;
        if (t[11:8]  > 4'd4) t[11:8]  = t[11:8]  + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [7:0] frac_ascii(input logic [7:0] b);
        return (b > 8'd9) ? 8'h39 : {4'h3, b[3:0]};
    endfunction

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        chr_d       = chr_q;
        last_d      = last_q;
        conv_d      = conv_q;
        dd_h_d      = dd_h_q;
        dd_t_d      = dd_t_q;
        frac_h_d    = frac_h_q;
        frac_t_d    = frac_t_q;
        msg_d       = msg_q;
        done_meta_d = done;
        done_sync_d = done_meta_q;
        done_prev_d = done_sync_q;
`ifdef DHT_REPORT_ERR_EN
        erro_meta_d = erro;
        erro_sync_d = erro_meta_q;
        erro_prev_d = erro_sync_q;
`endif

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                chr_d  = '0;
                // done beats erro when both edges land together
                if (done_evt) begin
                    state_d  = CONV;
                    busy_d   = 1'b1;
                    conv_d   = '0;
                    dd_h_d   = {12'd0, data_valid[31:24]};
                    dd_t_d   = {12'd0, data_valid[15:8]};
                    frac_h_d = frac_ascii(data_valid[23:16]);
                    frac_t_d = frac_ascii(data_valid[7:0]);
                end else if (err_evt) begin
                    state_d  = START;
                    busy_d   = 1'b1;
                    tx_d     = 1'b0;
                    last_d   = LAST_ERR;
                    msg_d[0] = "E";
                    msg_d[1] = "R";
                    msg_d[2] = "R";
                    msg_d[3] = 8'h0D;
                    msg_d[4] = 8'h0A;
                end
            end

            CONV: begin
                dd_h_d = dd_step(dd_h_q);
                dd_t_d = dd_step(dd_t_q);
                conv_d = conv_q + 3'd1;
                if (conv_q == 3'd7) begin
                    state_d   = START;
                    tx_d      = 1'b0;
                    last_d    = LAST_DATA;
                    msg_d[0]  = "H";
                    msg_d[1]  = "=";
                    msg_d[2]  = {4'h3, dd_h_d[19:16]};
                    msg_d[3]  = {4'h3, dd_h_d[15:12]};
                    msg_d[4]  = {4'h3, dd_h_d[11:8]};
                    msg_d[5]  = ".";
                    msg_d[6]  = frac_h_q;
                    msg_d[7]  = " ";
                    msg_d[8]  = "T";
                    msg_d[9]  = "=";
                    msg_d[10] = {4'h3, dd_t_d[19:16]};
                    msg_d[11] = {4'h3, dd_t_d[15:12]};
                    msg_d[12] = {4'h3, dd_t_d[11:8]};
                    msg_d[13] = ".";
                    msg_d[14] = frac_t_q;
                    msg_d[15] = 8'h0D;
                    msg_d[16] = 8'h0A;
                end
            end

            START: begin
                baud_d = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = msg_q[chr_q][0];
                end
            end

            DATA: begin
                baud_d = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = msg_q[chr_q][bit_q + 3'd1];
                    end
                end
            end

            STOP: begin
                baud_d = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    if (chr_q == last_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = cnt_q + 8'd1;
                    end else begin
                        chr_d   = chr_q + 5'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            chr_q       <= '0;
            last_q      <= '0;
            conv_q      <= '0;
            dd_h_q      <= '0;
            dd_t_q      <= '0;
            frac_h_q    <= '0;
            frac_t_q    <= '0;
            for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= '0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
            done_prev_q <= 1'b0;
`ifdef DHT_REPORT_ERR_EN
            erro_meta_q <= 1'b0;
            erro_sync_q <= 1'b0;
            erro_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            chr_q       <= chr_d;
            last_q      <= last_d;
            conv_q      <= conv_d;
            dd_h_q      <= dd_h_d;
            dd_t_q      <= dd_t_d;
            frac_h_q    <= frac_h_d;
            frac_t_q    <= frac_t_d;
            msg_q       <= msg_d;
            done_meta_q <= done_meta_d;
            done_sync_q <= done_sync_d;
            done_prev_q <= done_prev_d;
`ifdef DHT_REPORT_ERR_EN
            erro_meta_q <= erro_meta_d;
            erro_sync_q <= erro_sync_d;
            erro_prev_q <= erro_prev_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign report_cnt = cnt_q;

endmodule
`default_nettype wire
